shift_seq_unit: RTL and testbench
=================================

// Module: shift_seq_unit
// PURPOSE
//   Parametrised, multi-cycle successor to the combinational shift/concat operator block.
//   - Shift/rotate engine moves operand a by one bit per clock.
//   - Concat and replication complete in a single cycle.
//   - valid/ready handshake on input and output; sits between an operand source and a result consumer.
// PARAMETERS
//   W   8   operand width; power of two, >= 4
//   SW  $clog2(W)+1   shamt width (derived, localparam)
// PORTS
//   clk        in   1     clock, all logic on rising edge
//   rst        in   1     synchronous reset, active-high
//   in_valid   in   1     operands/mode/shamt valid
//   in_ready   out  1     unit can accept (1 only in IDLE)
//   in_a       in   W     primary operand (shifted/rotated)
//   in_b       in   W     secondary operand (concat only)
//   in_mode    in   3     0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5 CONCAT {b,a}, 6 REPL {a,a}, 7 PASS
//   in_shamt   in   SW    shift amount
//   out_valid  out  1     result valid, held until taken
//   out_ready  in   1     consumer accepts result
//   out_data   out  2*W   result
//   out_ovf    out  1     sticky shifted-out-one flag (only with SHIFT_SEQ_OVF_EN)
// BEHAVIOUR
//   - Reset: state IDLE, out_valid=0, out_data=0, out_ovf=0, internal count=0. in_ready=1 after reset.
//   - FSM: IDLE -> SHIFT or DONE on accept (in_valid&&in_ready). SHIFT -> DONE when last step done.
//     DONE -> IDLE on out_valid&&out_ready.
//   - in_ready = (state==IDLE). in_valid is ignored in SHIFT and DONE. No same-cycle bypass.
//   - Step count n:
//     - LSL/LSR/ASR: n = min(shamt, W).
//     - ROL/ROR: n = shamt mod W.
//     - CONCAT/REPL/PASS: n = 0.
//   - Accept with n=0: next state DONE; out_valid visible the cycle after accept.
//   - Accept with n>0: capture a into work register, cnt=n, enter SHIFT.
//     Each SHIFT cycle performs one 1-bit step and decrements cnt; cnt==1 -> DONE.
//     Latency from accept edge to out_valid = 1+n cycles.
//   - Step rules:
//     - LSL: insert 0 at LSB.
//     - LSR: insert 0 at MSB.
//     - ASR: replicate MSB.
//     - ROL/ROR: circular.
//   - out_data:
//     - Shift/rotate/PASS: {W'b0, work}.
//     - CONCAT: {in_b, in_a}.
//     - REPL: {in_a, in_a}. All operands are captured at accept.
//   - out_data and out_valid stay stable while out_valid && !out_ready; no input is accepted during that time.
//   - Shift by >= W: LSL/LSR give 0; ASR gives all-sign. Takes W cycles (saturated n).
//   - rst mid-operation (SHIFT or DONE): next cycle IDLE, out_valid=0, any pending result discarded.
// CONFIGURATION
//   SHIFT_SEQ_OVF_EN defined:
//     - out_ovf port exists. Cleared on accept.
//     - Set if any bit of value 1 leaves the word during an LSL, LSR or ASR step.
//     - Stays 0 for rotate/CONCAT/REPL/PASS.
//     - Valid with out_valid.
//   SHIFT_SEQ_OVF_EN undefined:
//     - out_ovf port and its logic are absent.
//     - All other behaviour is identical.
// TESTING (W=8)
//   1. LSL a=8'b1011_0110, shamt=2 -> out_data=16'h00D8, out_valid 3 cycles after accept, out_ovf=1.
//   2. ASR a=8'h90, shamt=3 -> 16'h00F2. LSR same operands -> 16'h0012. Both at latency 4.
//   3. ROR a=8'hA5, shamt=12 (mod 8 = 4) -> 16'h005A, latency 5.
//      ROL a=8'h81, shamt=8 -> 16'h0081, latency 1.
//   4. CONCAT a=8'h3C, b=8'hC3 -> 16'hC33C. REPL a=8'h3C -> 16'h3C3C. Both latency 1.
//   5. out_ready low for 5 cycles after out_valid -> out_data and out_valid stable, in_ready=0,
//      toggling in_valid is not accepted; out_ready=1 -> IDLE next cycle.
//   6. rst pulse while in SHIFT with cnt=5 -> next cycle IDLE, out_valid=0, in_ready=1.
//      A following LSL shamt=1 of 8'h01 -> 16'h0002.

Source files
------------

// File: rtl/shift_seq_unit.sv
// shift_seq_unit
//   Multi-cycle shift/rotate unit with single-cycle concat and replicate.
//   The shift and rotate engine moves operand a by one bit per clock.
//   Inputs and outputs each use a valid/ready handshake.
//
// Parameters
//   W   operand width (power of two, >= 4)
//   SW  shift-amount width, $clog2(W)+1 (derived)
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   in_valid   operand/mode/shamt valid
//   in_ready   unit idle and able to accept
//   in_a       primary operand (shifted/rotated)
//   in_b       secondary operand (concat only)
//   in_mode    0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5 CONCAT {b,a}, 6 REPL {a,a}, 7 PASS
//   in_shamt   shift amount
//   out_valid  result valid, held until taken
//   out_ready  consumer accepts result
//   out_data   2*W-bit result
//   out_ovf    sticky flag: a set bit was shifted out (present only with SHIFT_SEQ_OVF_EN)
//
// Build option: define SHIFT_SEQ_OVF_EN to add the out_ovf port and its logic.
module shift_seq_unit #(
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [2:0]      in_mode,
  input  logic [SW-1:0]   in_shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data
`ifdef SHIFT_SEQ_OVF_EN
  ,
  output logic            out_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    M_LSL, M_LSR, M_ASR, M_ROL, M_ROR, M_CONCAT, M_REPL, M_PASS
  } mode_t;

  state_t        state, state_nxt;
  mode_t         mode_r;
  logic [W-1:0]  work;
  logic [W-1:0]  hi;
  logic [SW-1:0] cnt;
  logic [SW-1:0] n_calc;
  logic          accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = {hi, work};
  assign accept    = in_valid && in_ready;

  // Step count: shifts saturate at W, rotates wrap modulo W (W is a power of two).
  always_comb begin
    n_calc = '0;
    case (mode_t'(in_mode))
      M_LSL, M_LSR, M_ASR: n_calc = (in_shamt >= SW'(W)) ? SW'(W) : in_shamt;
      M_ROL, M_ROR:        n_calc = in_shamt & SW'(W - 1);
      default:             n_calc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (n_calc == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      hi     <= '0;
      cnt    <= '0;
      mode_r <= M_LSL;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mode_r <= mode_t'(in_mode);
            cnt    <= n_calc;
            work   <= in_a;
            case (mode_t'(in_mode))
              M_CONCAT: hi <= in_b;
              M_REPL:   hi <= in_a;
              default:  hi <= '0;
            endcase
          end
        end
        SHIFT: begin
          cnt <= cnt - SW'(1);
          case (mode_r)
            M_LSL:   work <= {work[W-2:0], 1'b0};
            M_LSR:   work <= {1'b0, work[W-1:1]};
            M_ASR:   work <= {work[W-1], work[W-1:1]};
            M_ROL:   work <= {work[W-2:0], work[W-1]};
            M_ROR:   work <= {work[0], work[W-1:1]};
            default: work <= work;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_SEQ_OVF_EN
  logic ovf_r;

  // The bit leaving the word on this step is the MSB for LSL and the LSB for LSR/ASR.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (accept) begin
      ovf_r <= 1'b0;
    end else if (state == SHIFT) begin
      case (mode_r)
        M_LSL:        if (work[W-1]) ovf_r <= 1'b1;
        M_LSR, M_ASR: if (work[0])   ovf_r <= 1'b1;
        default: ;
      endcase
    end
  end

  assign out_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_mode;
  logic [SW-1:0] in_shamt;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_data;
`ifdef SHIFT_SEQ_OVF_EN
  logic          out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  shift_seq_unit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result, step count and overflow from plain integer arithmetic.
  task automatic ref_model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sh, output int n, output logic [15:0] d,
                           output logic ovf);
    int av, sa, s, r;
    av  = int'(a);
    s   = int'(sh);
    sa  = a[7] ? av - 256 : av;
    ovf = 1'b0;
    n   = 0;
    r   = 0;
    case (m)
      3'd0: begin
        n = (s > 8) ? 8 : s;
        r = (av << n) & 255;
        ovf = ((av << n) >> 8) != 0;
      end
      3'd1: begin
        n = (s > 8) ? 8 : s;
        r = av >> n;
        ovf = (av & ((1 << n) - 1)) != 0;
      end
      3'd2: begin
        n = (s > 8) ? 8 : s;
        r = (sa >>> n) & 255;
        ovf = (av & ((1 << n) - 1)) != 0;
      end
      3'd3: begin
        n = s % 8;
        r = ((av << n) | (av >> (8 - n))) & 255;
      end
      3'd4: begin
        n = s % 8;
        r = ((av >> n) | (av << (8 - n))) & 255;
      end
      3'd5: r = int'(b) * 256 + av;
      3'd6: r = av * 257;
      default: r = av;
    endcase
    d = 16'(r);
  endtask

  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sh, input int stall);
    int n, lat;
    logic [15:0] exp_d;
    logic exp_o;
    ref_model(m, a, b, sh, n, exp_d, exp_o);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_shamt = sh; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    // Inputs toggle freely while busy; none of it may be taken.
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom); in_b = 8'($urandom);
      in_mode = 3'($urandom); in_shamt = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(n + 1));
    check("data", 32'(out_data), 32'(exp_d));
`ifdef SHIFT_SEQ_OVF_EN
    check("ovf", 32'(out_ovf), 32'(exp_o));
`endif
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 8'($urandom); in_mode = 3'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_data", 32'(out_data), 32'(exp_d));
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("taken_valid", 32'(out_valid), 32'd0);
    check("taken_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_shamt = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFT_SEQ_OVF_EN
    check("rst_ovf", 32'(out_ovf), 32'd0);
`endif

    run_op(3'd0, 8'hB6, 8'h00, 4'd2, 0);
    run_op(3'd2, 8'h90, 8'h00, 4'd3, 0);
    run_op(3'd1, 8'h90, 8'h00, 4'd3, 1);
    run_op(3'd4, 8'hA5, 8'h00, 4'd12, 0);
    run_op(3'd3, 8'h81, 8'h00, 4'd8, 0);
    run_op(3'd5, 8'h3C, 8'hC3, 4'd5, 0);
    run_op(3'd6, 8'h3C, 8'h99, 4'd0, 0);
    run_op(3'd7, 8'h77, 8'h11, 4'd9, 5);
    run_op(3'd0, 8'hFF, 8'h00, 4'd15, 0);
    run_op(3'd2, 8'h80, 8'h00, 4'd9, 2);
    run_op(3'd1, 8'hFF, 8'h00, 4'd8, 0);

    // Reset while shifting (LSL saturated to 8 steps; cnt reaches 5 after 3 steps).
    @(negedge clk);
    in_valid = 1'b1; in_mode = 3'd0; in_a = 8'hF0; in_shamt = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    run_op(3'd0, 8'h01, 8'h00, 4'd1, 0);

    // Reset while a result is waiting.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 3'd5; in_a = 8'h12; in_b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    check("done_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("donerst_out_valid", 32'(out_valid), 32'd0);
    check("donerst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 300; i++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
